// File: rtl/timestamp_deframer.sv
// Receive-side deframer for the timestamp sync framing: recovers word alignment
// from FF x7 + 00, strips the 00 prefix, drops sync words and emits 48-bit timestamps.
module timestamp_deframer #(
    parameter int unsigned SYNC_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [47:0] out_data,
    input  logic        out_ready,
    output logic        locked,
    output logic        frame_error
);

    localparam int unsigned CTR_W = $clog2(SYNC_TIMEOUT + 1) + 1;
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(SYNC_TIMEOUT > 0 ? SYNC_TIMEOUT - 1 : 0);

    typedef enum logic [0:0] {StHunt, StLocked} state_e;
    typedef enum logic [0:0] {KindData, KindSync} kind_e;

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic [2:0]        ff_run_q, ff_run_d;
    logic [2:0]        byte_idx_q, byte_idx_d;
    logic [CTR_W-1:0]  word_ctr_q, word_ctr_d;
    logic [39:0]       asm_q, asm_d;
    logic              out_valid_q, out_valid_d;
    logic [47:0]       out_data_q, out_data_d;
    logic              frame_error_q, frame_error_d;
    logic              accept;
    logic              bad_byte;
    logic              timed_out;

    assign in_ready    = !out_valid_q || out_ready;
    assign accept      = in_valid && in_ready;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign locked      = (state_q == StLocked);
    assign frame_error = frame_error_q;

    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        ff_run_d      = ff_run_q;
        byte_idx_d    = byte_idx_q;
        word_ctr_d    = word_ctr_q;
        asm_d         = asm_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        frame_error_d = 1'b0;
        bad_byte      = 1'b0;
        timed_out     = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            unique case (state_q)
                StHunt: begin
                    if (in_data == 8'hFF) begin
                        if (ff_run_q != 3'd7) begin
                            ff_run_d = ff_run_q + 3'd1;
                        end
                    end else if (in_data == 8'h00 && ff_run_q == 3'd7) begin
                        state_d    = StLocked;
                        kind_d     = KindData;
                        byte_idx_d = 3'd1;
                        ff_run_d   = 3'd0;
                        word_ctr_d = '0;
                    end else begin
                        ff_run_d = 3'd0;
                    end
                end
                StLocked: begin
                    byte_idx_d = (byte_idx_q == 3'd6) ? 3'd0 : byte_idx_q + 3'd1;
                    if (byte_idx_q == 3'd0) begin
                        if (in_data == 8'h00) begin
                            kind_d = KindData;
                        end else if (in_data == 8'hFF) begin
                            kind_d     = KindSync;
                            word_ctr_d = '0;
                        end else begin
                            bad_byte = 1'b1;
                        end
                    end else if (kind_q == KindSync) begin
                        if (in_data != 8'hFF) begin
                            bad_byte = 1'b1;
                        end else if (byte_idx_q == 3'd6) begin
                            word_ctr_d = '0;
                        end
                    end else begin
                        asm_d = {asm_q[31:0], in_data};
                        if (byte_idx_q == 3'd6) begin
                            out_valid_d = 1'b1;
                            out_data_d  = {asm_q, in_data};
                            word_ctr_d  = word_ctr_q + CTR_W'(1);
                            // The word that exhausts the budget is still delivered.
                            timed_out   = (SYNC_TIMEOUT > 0) && (word_ctr_q == CTR_LAST);
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end

        if (bad_byte || timed_out) begin
            state_d       = StHunt;
            ff_run_d      = 3'd0;
            byte_idx_d    = 3'd0;
            frame_error_d = bad_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StHunt;
            kind_q        <= KindData;
            ff_run_q      <= 3'd0;
            byte_idx_q    <= 3'd0;
            word_ctr_q    <= '0;
            asm_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            ff_run_q      <= ff_run_d;
            byte_idx_q    <= byte_idx_d;
            word_ctr_q    <= word_ctr_d;
            asm_q         <= asm_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            frame_error_q <= frame_error_d;
        end
    end

endmodule

// File: tb/tb_timestamp_deframer.sv
// Directed bench for timestamp_deframer: one instance without timeout, one with
// SYNC_TIMEOUT=2 sharing the same byte stream.
module tb_timestamp_deframer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        in_ready, out_valid, locked, frame_error;
    logic [47:0] out_data;
    logic        to_in_ready, to_out_valid, to_locked, to_frame_error;
    logic [47:0] to_out_data;

    logic [47:0] q[$];
    logic [47:0] q_to[$];
    int          fe_cnt = 0;
    int          to_fe_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    timestamp_deframer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .locked      (locked),
        .frame_error (frame_error)
    );

    timestamp_deframer #(.SYNC_TIMEOUT(2)) dut_to (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (to_in_ready),
        .out_valid   (to_out_valid),
        .out_data    (to_out_data),
        .out_ready   (out_ready),
        .locked      (to_locked),
        .frame_error (to_frame_error)
    );

    // Words are recorded on the falling edge before the rising edge that consumes them.
    always @(negedge clk) begin
        if (out_valid && out_ready) q.push_back(out_data);
        if (to_out_valid && out_ready) q_to.push_back(to_out_data);
        if (frame_error) fe_cnt++;
        if (to_frame_error) to_fe_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [47:0] ts);
        send_byte(b0);
        for (int i = 5; i >= 0; i--) send_byte(ts[i*8 +: 8]);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_byte(8'hFF);
    endtask

    function automatic logic [47:0] pop();
        if (q.size() > 0) return q.pop_front();
        return 48'hDEAD_0000_0000;
    endfunction

    function automatic logic [47:0] pop_to();
        if (q_to.size() > 0) return q_to.pop_front();
        return 48'hDEAD_0000_0000;
    endfunction

    int fe_base;

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        do_reset();

        // Reset state
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_frame_error", 64'(frame_error), 64'd0);
        check("rst_in_ready", 64'({in_ready, to_in_ready}), 64'd3);

        // 1: basic lock and first word
        send_sync();
        check("t1_not_locked_on_ff", 64'(locked), 64'd0);
        send_byte(8'h00);
        check("t1_locked_after_00", 64'(locked), 64'd1);
        for (int i = 1; i <= 6; i++) send_byte(8'(8'h11 * i));
        tick(3);
        check("t1_count", 64'(q.size()), 64'd1);
        check("t1_data", 64'(pop()), 64'h112233445566);

        // 2: sync between two data words
        fe_base = fe_cnt;
        send_word(8'h00, 48'hA1A2A3A4A5A6);
        send_sync();
        send_word(8'h00, 48'hB1B2B3B4B5B6);
        tick(3);
        check("t2_count", 64'(q.size()), 64'd2);
        check("t2_data0", 64'(pop()), 64'hA1A2A3A4A5A6);
        check("t2_data1", 64'(pop()), 64'hB1B2B3B4B5B6);
        check("t2_no_fe", 64'(fe_cnt - fe_base), 64'd0);
        check("t2_locked", 64'(locked), 64'd1);

        // 3: leading garbage
        do_reset();
        q.delete();
        send_byte(8'hA5); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00);
        send_word(8'h11, 48'h223344556677);
        tick(3);
        check("t3_no_out", 64'(q.size()), 64'd0);
        check("t3_unlocked", 64'(locked), 64'd0);
        send_sync();
        send_word(8'h00, 48'hC0C1C2C3C4C5);
        send_word(8'h00, 48'hD0D1D2D3D4D5);
        tick(3);
        check("t3_count", 64'(q.size()), 64'd2);
        check("t3_data0", 64'(pop()), 64'hC0C1C2C3C4C5);
        check("t3_data1", 64'(pop()), 64'hD0D1D2D3D4D5);

        // 4: bad byte 0 loses lock
        fe_base = fe_cnt;
        send_byte(8'h7E);
        check("t4_fe_pulse", 64'(frame_error), 64'd1);
        tick(2);
        check("t4_fe_count", 64'(fe_cnt - fe_base), 64'd1);
        check("t4_unlocked", 64'(locked), 64'd0);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        send_word(8'h00, 48'h0A0B0C0D0E0F);
        tick(3);
        check("t4_no_out", 64'(q.size()), 64'd0);
        send_sync();
        send_word(8'h00, 48'hE1E2E3E4E5E6);
        tick(3);
        check("t4_resume_count", 64'(q.size()), 64'd1);
        check("t4_resume_data", 64'(pop()), 64'hE1E2E3E4E5E6);

        // 5: all-FF payload is data
        fe_base = fe_cnt;
        send_word(8'h00, 48'hFFFFFFFFFFFF);
        send_sync();
        send_word(8'h00, 48'h010203040506);
        tick(3);
        check("t5_count", 64'(q.size()), 64'd2);
        check("t5_data0", 64'(pop()), 64'hFFFFFFFFFFFF);
        check("t5_data1", 64'(pop()), 64'h010203040506);
        check("t5_locked", 64'(locked), 64'd1);
        check("t5_no_fe", 64'(fe_cnt - fe_base), 64'd0);

        // 6: backpressure, then reset mid-word and with a pending word
        out_ready = 1'b0;
        send_word(8'h00, 48'h5A5B5C5D5E5F);
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t6_in_ready_low", 64'(in_ready), 64'd0);
            check("t6_data_held", 64'(out_data), 64'h5A5B5C5D5E5F);
        end
        check("t6_valid_held", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick(3);
        check("t6_count", 64'(q.size()), 64'd1);
        check("t6_data", 64'(pop()), 64'h5A5B5C5D5E5F);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        do_reset();
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_locked", 64'(locked), 64'd0);
        send_byte(8'h03); send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
        tick(3);
        check("t6_partial_dropped", 64'(q.size()), 64'd0);
        out_ready = 1'b0;
        send_sync();
        send_word(8'h00, 48'h777777777777);
        tick(1);
        check("t6_pending", 64'(out_valid), 64'd1);
        do_reset();
        check("t6_pending_cleared", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        tick(3);
        check("t6_pending_dropped", 64'(q.size()), 64'd0);

        // 7: timeout after two data words without sync
        do_reset();
        q.delete();
        q_to.delete();
        to_fe_cnt = 0;
        send_sync();
        send_word(8'h00, 48'h0A0B0C0D0E0F);
        tick(1);
        check("t7_locked_after_w1", 64'(to_locked), 64'd1);
        send_word(8'h00, 48'h102030405060);
        tick(3);
        check("t7_count", 64'(q_to.size()), 64'd2);
        check("t7_data0", 64'(pop_to()), 64'h0A0B0C0D0E0F);
        check("t7_data1", 64'(pop_to()), 64'h102030405060);
        check("t7_unlocked", 64'(to_locked), 64'd0);
        check("t7_no_fe", 64'(to_fe_cnt), 64'd0);
        check("t7_no_timeout_dut_locked", 64'(locked), 64'd1);
        check("t7_no_timeout_dut_count", 64'(q.size()), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
